// File: rtl/sram_pkg.sv
// Shared encodings and types for the SRAM request front-end and the bitline-mask stage.
// Latency: none (definitions only); backpressure: n/a.
package sram_pkg;

   localparam int ROW_BITS = 32;

   localparam logic [1:0] CONF_32   = 2'b00;
   localparam logic [1:0] CONF_16   = 2'b01;
   localparam logic [1:0] CONF_8    = 2'b10;
   localparam logic [1:0] CONF_RSVD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_WAIT  = 2'b10,
      ST_RESP  = 2'b11
   } state_t;

   // Registered per-request attributes; conf and lane also feed the mask stage.
   typedef struct packed {
      logic       we;
      logic [1:0] conf;
      logic [1:0] lane;
   } req_meta_t;

endpackage

// File: rtl/rdata_align_8_32_2.sv
// Extracts the addressed 32/16/8-bit word from a 32-bit row, zero-extended.
// Latency: combinational; backpressure: n/a.
module rdata_align_8_32_2
   import sram_pkg::*;
(
   input  logic [ROW_BITS-1:0] row_dat,
   input  logic [1:0]          conf,
   input  logic [1:0]          lane,
   output logic [ROW_BITS-1:0] rdata
);

   always_comb begin
      rdata = '0;
      case (conf)
         CONF_32: rdata        = row_dat;
         CONF_16: rdata[15:0]  = row_dat[16*lane[0] +: 16];
         CONF_8:  rdata[7:0]   = row_dat[8*lane +: 8];
         default: rdata        = '0;
      endcase
   end

endmodule

// File: rtl/sram_req_ctrl_32.sv
// Single-outstanding request front-end for a 32-bit configurable-width SRAM row.
// Latency: write resp N+2, read resp N+3, reserved conf N+1; resp_ready low stalls in RESP, req_ready low until resp consumed.
module sram_req_ctrl_32
   import sram_pkg::*;
#(
   parameter int ROW_W = 8
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [1:0]          req_conf,
   input  logic [ROW_W+1:0]    req_addr,
   input  logic [31:0]         req_wdata,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [31:0]         resp_rdata,
   output logic                resp_err,
   output logic                sram_ce,
   output logic                sram_we,
   output logic [ROW_W-1:0]    sram_row,
   output logic [31:0]         sram_wdata,
   input  logic [31:0]         sram_rdata,
   output logic [1:0]          mask_addr,
   output logic [1:0]          mask_conf
);

   state_t           state_q, state_d;
   req_meta_t        meta_q;
   logic [ROW_W-1:0] row_d;
   logic [1:0]       lane_d;
   logic [31:0]      wrep_d;
   logic [31:0]      rdata_q;
   logic [31:0]      rdata_aln;
   logic             err_q;
   logic             accept;

   // Address split and write replication, in units of the configured word.
   always_comb begin
      row_d  = req_addr[ROW_W-1:0];
      lane_d = 2'b00;
      wrep_d = req_wdata;
      case (req_conf)
         CONF_16: begin
            row_d  = req_addr[ROW_W:1];
            lane_d = {1'b0, req_addr[0]};
            wrep_d = {2{req_wdata[15:0]}};
         end
         CONF_8: begin
            row_d  = req_addr[ROW_W+1:2];
            lane_d = req_addr[1:0];
            wrep_d = {4{req_wdata[7:0]}};
         end
         default: ;
      endcase
   end

   rdata_align_8_32_2 u_align (
      .row_dat (sram_rdata),
      .conf    (meta_q.conf),
      .lane    (meta_q.lane),
      .rdata   (rdata_aln)
   );

   // Handshake-visible outputs are gated by rst so the reset cycle itself is quiet.
   always_comb begin
      state_d    = state_q;
      req_ready  = 1'b0;
      sram_ce    = 1'b0;
      resp_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready = !rst;
            if (req_valid) begin
               state_d = (req_conf == CONF_RSVD) ? ST_RESP : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            sram_ce = !rst;
            state_d = meta_q.we ? ST_RESP : ST_WAIT;
         end
         ST_WAIT: begin
            state_d = ST_RESP;
         end
         ST_RESP: begin
            resp_valid = !rst;
            if (resp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign accept     = req_valid && req_ready;
   assign sram_we    = sram_ce && meta_q.we;
   assign mask_addr  = meta_q.lane;
   assign mask_conf  = meta_q.conf;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         meta_q     <= '0;
         sram_row   <= '0;
         sram_wdata <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            meta_q     <= '{we: req_we, conf: req_conf, lane: lane_d};
            sram_row   <= row_d;
            sram_wdata <= wrep_d;
            rdata_q    <= '0;
            err_q      <= (req_conf == CONF_RSVD);
         end
         if (state_q == ST_WAIT) begin
            rdata_q <= rdata_aln;
         end
      end
   end

endmodule

// File: doc/sram_req_ctrl_32.md
# sram_req_ctrl_32

Request front-end for the configurable-width 32-bit SRAM row. Accepts one read or write request at a time over a valid/ready handshake with per-request word width (32/16/8 bits). It splits the address into row index and lane, and replicates write data across lanes. It drives the SRAM macro strobes, plus the lane/width pair consumed by the downstream bitline-mask stage, and returns lane-aligned read data over a valid/ready response channel. It sits directly upstream of the bitline-mask decoder and the SRAM macro.

## Interface
- ROW_W, 8, row index width (macro depth = 2^ROW_W rows of 32 bits)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_we  in  1  1 = write, 0 = read
- req_conf  in  2  width: 00 = 32b, 01 = 16b, 10 = 8b, 11 = reserved
- req_addr  in  ROW_W+2  address in units of the configured word
- req_wdata  in  32  write data, low 32/16/8 bits significant
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed when resp_valid && resp_ready
- resp_rdata  out  32  read data, zero-extended; 0 for writes
- resp_err  out  1  request used reserved conf
- sram_ce  out  1  macro chip enable, one-cycle pulse
- sram_we  out  1  macro write enable, qualified by sram_ce
- sram_row  out  ROW_W  row index
- sram_wdata  out  32  lane-replicated write data
- sram_rdata  in  32  macro read data, valid the cycle after a read sram_ce
- mask_addr  out  2  lane select to bitline-mask stage
- mask_conf  out  2  width to bitline-mask stage

## Operation
- Address split, in units of the configured word:
  - 32b: row = addr[ROW_W-1:0], lane = 00.
  - 16b: row = addr[ROW_W:1], lane = {0, addr[0]}.
  - 8b: row = addr[ROW_W+1:2], lane = addr[1:0].
  - Unused high address bits are ignored.
- Write replication:
  - 32b: wdata as-is.
  - 16b: {2{wdata[15:0]}}.
  - 8b: {4{wdata[7:0]}}.
  - The mask stage gates the lanes that are not written.
- Read extraction:
  - 32b: whole row.
  - 16b: row[16*lane[0] +: 16], zero-extended.
  - 8b: row[8*lane +: 8], zero-extended.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: req_ready = 1. On handshake, register we, conf, row, lane and replicated wdata, then go to ISSUE.
  - ISSUE: sram_ce = 1 and sram_we = we. Next state is WAIT for a read, RESP for a write.
  - WAIT: capture the extracted sram_rdata into the response register, then go to RESP.
  - RESP: resp_valid = 1. All response outputs are held stable until resp_ready; on handshake, return to IDLE.
- Reserved conf (11): the request is accepted and FSM goes IDLE -> RESP directly, with no sram_ce. Response is resp_err = 1, resp_rdata = 0.
- mask_addr and mask_conf come from the registered request. They are held from ISSUE through RESP, so they are stable whenever sram_ce is high.

## Timing
- Reset, synchronous and taking priority over everything:
  - state = IDLE.
  - req_ready = 0 while rst is high, 1 the cycle after.
  - resp_valid = 0, sram_ce = 0, sram_we = 0.
  - sram_row, sram_wdata, mask_addr, mask_conf, resp_rdata and resp_err = 0.
- Reset mid-operation: an in-flight request is dropped. No response is produced, and sram_ce deasserts in the reset cycle.
- Latency with handshake in cycle N:
  - Write: sram_ce in N+1, resp_valid from N+2.
  - Read: sram_ce in N+1, sram_rdata sampled in N+2, resp_valid from N+3.
  - Reserved conf: resp_valid from N+1.
- Throughput is one request in flight. req_ready is low in ISSUE, WAIT and RESP.
- The earliest next accept follows the cycle in which the response is consumed. There is no same-cycle resp-to-req bypass.
- resp_ready held low stalls indefinitely in RESP with no SRAM activity.
- req_* inputs are ignored when req_ready = 0.
- sram_ce never asserts outside ISSUE and is exactly one cycle per legal request.

## Structure
- Package sram_pkg holds:
  - conf encodings CONF_32 = 2'b00, CONF_16 = 2'b01, CONF_8 = 2'b10, CONF_RSVD = 2'b11;
  - the FSM state typedef;
  - a ROW_BITS = 32 constant.
- sram_pkg is shared with the bitline-mask stage, which uses the same conf encodings.
- One sub-module, rdata_align_8_32_2, is combinational: inputs row data, conf and lane; output is extracted, zero-extended data. The verifier reuses it as a reference model.
- Top contains the FSM, request and response registers, and write replication.

## Test plan
- Reset, then a write with conf=00, addr=0x005, wdata=0xDEADBEEF.
  - Expect sram_ce in N+1 with sram_we=1, row=5, sram_wdata=0xDEADBEEF, mask_conf=00.
  - Expect resp_valid at N+2 with err=0.
- 8-bit write with addr=0x00E, wdata=0x000000A5.
  - Expect row=3, mask_addr=10, mask_conf=10, sram_wdata=0xA5A5A5A5.
- 16-bit read with addr=0x007, model returning 0x12345678.
  - Expect row=3, mask_addr=01, resp_valid at N+3, resp_rdata=0x00001234.
- Reserved conf=11 request.
  - Expect no sram_ce, resp_valid at N+1, resp_err=1, resp_rdata=0.
- Backpressure: hold resp_ready=0 for 5 cycles on a read response.
  - Expect resp_rdata stable, req_ready=0 and no sram_ce throughout.
  - Next request is accepted only in the cycle after the response handshake.
- Assert rst in the ISSUE cycle of a read.
  - Expect sram_ce=0 that cycle and no resp_valid afterwards.
  - Expect req_ready=1 the cycle after rst deasserts.
